// File: rtl/ssd1680_spi_responder.sv
// SSD1680-style SPI command responder: receives mode-0 SPI bytes, decodes a subset of the
// controller command set and emits RAM write strobes, busy and deep-sleep status.
module ssd1680_spi_responder #(
  parameter int unsigned BUSY_CYCLES = 16,
  parameter int unsigned RST_CYCLES  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csb,
  input  logic        sck,
  input  logic        mosi,
  input  logic        dcb,
  input  logic        hw_resb,
  output logic        busy,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        byte_vld,
  output logic        byte_dc,
  output logic [7:0]  byte_val,
  output logic        sleeping,
  output logic        proto_err
);

  localparam int unsigned CntW = (BUSY_CYCLES < 2) ? 1 : $clog2(BUSY_CYCLES + 1);
  localparam int unsigned RstW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StParam, StBusy, StSleep} state_e;

  logic [1:0] csb_sync_q, sck_sync_q, mosi_sync_q, dcb_sync_q, hw_sync_q;
  logic       csb_prev_q, sck_prev_q;
  logic       csb_s, sck_s, mosi_s, dcb_s, hw_s;
  logic       csb_fall, csb_rise, sck_rise;

  // csb chain resets low so a select already held low at reset release is not taken as a
  // falling edge; reception re-arms only after csb is seen high then low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb_sync_q  <= 2'b00;
      sck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      dcb_sync_q  <= 2'b00;
      hw_sync_q   <= 2'b11;
      csb_prev_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
    end else begin
      csb_sync_q  <= {csb_sync_q[0], csb};
      sck_sync_q  <= {sck_sync_q[0], sck};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      dcb_sync_q  <= {dcb_sync_q[0], dcb};
      hw_sync_q   <= {hw_sync_q[0], hw_resb};
      csb_prev_q  <= csb_s;
      sck_prev_q  <= sck_s;
    end
  end

  assign csb_s    = csb_sync_q[1];
  assign sck_s    = sck_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign dcb_s    = dcb_sync_q[1];
  assign hw_s     = hw_sync_q[1];
  assign csb_fall = csb_prev_q & ~csb_s;
  assign csb_rise = ~csb_prev_q & csb_s;
  assign sck_rise = sck_s & ~sck_prev_q;

  // Hardware reset qualification
  logic [RstW-1:0] hw_cnt_q, hw_cnt_d;
  logic            hw_rst;

  always_comb begin
    hw_rst   = ~hw_s && (hw_cnt_q >= RstW'(RST_CYCLES - 1));
    hw_cnt_d = hw_cnt_q;
    if (hw_s) begin
      hw_cnt_d = '0;
    end else if (hw_cnt_q < RstW'(RST_CYCLES - 1)) begin
      hw_cnt_d = hw_cnt_q + RstW'(1);
    end
  end

  // Shift register
  logic       armed_q, armed_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       byte_done, abort_err;
  logic [7:0] rx_byte;

  assign rx_byte = {shift_q[6:0], mosi_s};

  always_comb begin
    armed_d   = armed_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    abort_err = 1'b0;
    if (csb_fall) begin
      armed_d   = 1'b1;
      bit_cnt_d = '0;
    end else if (csb_rise) begin
      abort_err = armed_q && (bit_cnt_q != 3'd0);
      bit_cnt_d = '0;
    end else if (armed_q && !csb_s && sck_rise) begin
      shift_d   = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
      byte_done = (bit_cnt_q == 3'd7);
    end
    if (hw_rst) begin
      bit_cnt_d = '0;
      shift_d   = '0;
      byte_done = 1'b0;
    end
  end

  // Command FSM
  state_e          state_q, state_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      x_q, x_d;
  logic [7:0]      y_q, y_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cmd_dec, byte_err;
  logic            ram_we_d, byte_vld_d, byte_dc_d, proto_err_d;
  logic [11:0]     ram_addr_d;
  logic [7:0]      ram_wdata_d, byte_val_d;

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    idx_d       = idx_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    cmd_dec     = 1'b0;
    byte_err    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    byte_vld_d  = byte_done && (state_q != StSleep);
    byte_dc_d   = byte_dc;
    byte_val_d  = byte_val;
    if (byte_vld_d) begin
      byte_dc_d  = dcb_s;
      byte_val_d = rx_byte;
    end

    unique case (state_q)
      StIdle: begin
        if (byte_done) begin
          if (dcb_s) byte_err = 1'b1;
          else       cmd_dec  = 1'b1;
        end
      end
      StParam: begin
        if (byte_done && !dcb_s) begin
          cmd_dec = 1'b1;
        end else if (byte_done) begin
          if (idx_q != 4'hF) idx_d = idx_q + 4'd1;
          case (opcode_q)
            8'h4E: if (idx_q == 4'd0) x_d = rx_byte[3:0];
            8'h4F: if (idx_q == 4'd0) y_d = rx_byte;
            8'h24: begin
              ram_we_d    = 1'b1;
              ram_addr_d  = {y_q, x_q};
              ram_wdata_d = rx_byte;
              x_d         = x_q + 4'd1;
              if (x_q == 4'hF) y_d = y_q + 8'd1;
            end
            8'h10: if (idx_q == 4'd0 && rx_byte[0]) state_d = StSleep;
            default: ;
          endcase
        end
      end
      StBusy: begin
        if (byte_done) byte_err = 1'b1;
        // Leaving when the count would reach zero gives exactly BUSY_CYCLES busy cycles.
        if (cnt_q <= CntW'(1)) state_d = StIdle;
        else                   cnt_d   = cnt_q - CntW'(1);
      end
      StSleep: ;
      default: state_d = StIdle;
    endcase

    if (cmd_dec) begin
      case (rx_byte)
        8'h12: begin
          x_d     = '0;
          y_d     = '0;
          state_d = StBusy;
          cnt_d   = CntW'(BUSY_CYCLES);
        end
        8'h20: begin
          state_d = StBusy;
          cnt_d   = CntW'(BUSY_CYCLES);
        end
        default: begin
          opcode_d = rx_byte;
          idx_d    = '0;
          state_d  = StParam;
        end
      endcase
    end

    if (hw_rst) begin
      state_d  = StIdle;
      x_d      = '0;
      y_d      = '0;
      cnt_d    = '0;
      ram_we_d = 1'b0;
    end
    proto_err_d = proto_err | abort_err | (byte_err & ~hw_rst);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_cnt_q  <= '0;
      armed_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      state_q   <= StIdle;
      opcode_q  <= '0;
      idx_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      byte_vld  <= 1'b0;
      byte_dc   <= 1'b0;
      byte_val  <= '0;
      proto_err <= 1'b0;
    end else begin
      hw_cnt_q  <= hw_cnt_d;
      armed_q   <= armed_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
      byte_vld  <= byte_vld_d;
      byte_dc   <= byte_dc_d;
      byte_val  <= byte_val_d;
      proto_err <= proto_err_d;
    end
  end

  assign busy     = (state_q == StBusy) || (state_q == StSleep);
  assign sleeping = (state_q == StSleep);

endmodule

// File: doc/ssd1680_spi_responder.md
SSD1680_SPI_RESPONDER -- requirements
Module: ssd1680_spi_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 16: clk cycles busy is held after soft reset (0x12) or master activate (0x20).
REQ-002 SHALL have parameter RST_CYCLES, default 8: minimum clk cycles hw_resb must stay low to be accepted as a hardware reset.
REQ-003 clk  input  1  system clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-004 rst_n  input  1  asynchronous active-low digital reset.
REQ-005 csb  input  1  SPI select, active low, asynchronous to clk.
REQ-006 sck  input  1  SPI clock (mode 0), asynchronous to clk.
REQ-007 mosi  input  1  SPI serial data, MSB first.
REQ-008 dcb  input  1  0 = command byte, 1 = data byte.
REQ-009 hw_resb  input  1  display hardware reset, active low.
REQ-010 busy  output  1  display busy indication, high = busy.
REQ-011 ram_we  output  1  one-cycle RAM write strobe.
REQ-012 ram_addr  output  12  RAM byte address {y[7:0], x[3:0]}.
REQ-013 ram_wdata  output  8  RAM write data.
REQ-014 byte_vld  output  1  one-cycle strobe per complete received byte.
REQ-015 byte_dc  output  1  dcb value captured with the byte.
REQ-016 byte_val  output  8  received byte value.
REQ-017 sleeping  output  1  high while in deep sleep.
REQ-018 proto_err  output  1  sticky error flag; cleared only by reset.

Function
REQ-019 csb, sck, mosi, dcb and hw_resb SHALL each pass through a 2-flop synchronizer before use; the sck rising edge SHALL be detected on synchronized samples.
REQ-020 Each sck phase SHALL be at least 3 clk cycles; faster sck is out of scope.
REQ-021 On each synchronized sck rising edge with csb low, mosi SHALL be shifted into an 8-bit register, MSB first.
REQ-022 On the 8th bit, the block SHALL latch dcb, then byte_vld SHALL pulse exactly 3 clk cycles after the raw sck edge (2-cycle sync plus 1 register stage).
REQ-023 csb rising mid-byte SHALL discard the partial byte, set proto_err and restart the bit count; the bit count SHALL restart on every csb falling edge.
REQ-024 FSM states SHALL be IDLE, PARAM, BUSY and SLEEP.
REQ-025 IDLE: a command byte (dc=0) SHALL store the opcode, clear the parameter index and go to PARAM, except for opcodes 0x12, 0x20 and 0x10 (REQ-030 to REQ-032).
REQ-026 PARAM: each data byte SHALL increment the parameter index (saturating at 15); a command byte SHALL be decoded as in IDLE.
REQ-027 0x4E: data byte index 0 SHALL set x := byte[3:0].
REQ-028 0x4F: data byte index 0 SHALL set y := byte[7:0]; later indices SHALL be ignored.
REQ-029 0x24: every data byte SHALL drive ram_we=1 for 1 cycle with ram_addr={y,x} (values before increment) and ram_wdata=byte; then x SHALL increment; on x wrap 15->0, y SHALL increment; y SHALL wrap 255->0.
REQ-030 0x12: SHALL set x=0, y=0 and enter BUSY.
REQ-031 0x20: SHALL enter BUSY.
REQ-032 0x10: SHALL go to PARAM; data byte index 0 with bit0=1 SHALL enter SLEEP; bit0=0 SHALL have no effect.
REQ-033 All other opcodes (e.g. 0x11, 0x3C, 0x2C, 0x03, 0x04, 0x44, 0x45, 0x01, 0x22) SHALL be accepted and their parameters consumed without effect.
REQ-034 BUSY: busy=1; a counter SHALL load BUSY_CYCLES on entry and decrement every cycle; at 0 the FSM SHALL return to IDLE with busy=0 on the next cycle.
REQ-035 Any byte received in BUSY SHALL set proto_err and be discarded; byte_vld SHALL still pulse.
REQ-036 A data byte received in IDLE (no open command) SHALL set proto_err and be discarded.
REQ-037 SLEEP: sleeping=1 and busy=1; all bytes SHALL be ignored without error and byte_vld SHALL stay 0.
REQ-038 hw_resb low for at least RST_CYCLES synchronized cycles SHALL force IDLE, clear x, y, shift state and busy, and clear sleeping; a shorter pulse SHALL be ignored.
REQ-039 hw_resb low SHALL take priority over any simultaneous byte completion or busy expiry.

Reset
REQ-040 While rst_n is low, all outputs SHALL be 0 (busy=0, ram_we=0, ram_addr=0, ram_wdata=0, byte_vld=0, byte_dc=0, byte_val=0, sleeping=0, proto_err=0), the FSM SHALL be in IDLE and x=y=bit count=0.
REQ-041 Deassertion of rst_n mid-transaction SHALL resume reception only at the next csb falling edge.

Verification
REQ-042 Send cmd 0x12 -> byte_vld with dc=0 and val=0x12; busy high for 16 cycles, then 0.
REQ-043 Send 0x4E/0x01, 0x4F/0x00, then 0x24 plus 17 data bytes 0xA5 -> writes at addresses 0x001..0x00F, then 0x010, 0x011; all with wdata 0xA5.
REQ-044 Write with x=15, y=255 -> ram_addr=0xFFF, then the next write at 0x000.
REQ-045 Raise csb after 5 bits -> no byte_vld; proto_err=1; the next full byte is received correctly.
REQ-046 Send 0x10/0x01, then 0x12 -> sleeping=1, no byte_vld for 0x12; hw_resb low for 4 cycles -> still asleep; low for 8 cycles -> sleeping=0, FSM in IDLE.
REQ-047 Send a data byte right after reset -> proto_err=1, no ram_we.
